// File: rtl/src_pkg.sv
// Shared Mini-SRC definitions: opcodes, control-unit state encoding,
// and the bundle of datapath control strobes.
package src_pkg;

  localparam int IR_W    = 32;
  localparam int OPC_MSB = 31;

  localparam logic [4:0] OP_LD   = 5'd0;
  localparam logic [4:0] OP_LDI  = 5'd1;
  localparam logic [4:0] OP_ST   = 5'd2;
  localparam logic [4:0] OP_ADD  = 5'd3;
  localparam logic [4:0] OP_SUB  = 5'd4;
  localparam logic [4:0] OP_SHR  = 5'd5;
  localparam logic [4:0] OP_SHRA = 5'd6;
  localparam logic [4:0] OP_SHL  = 5'd7;
  localparam logic [4:0] OP_ROR  = 5'd8;
  localparam logic [4:0] OP_ROL  = 5'd9;
  localparam logic [4:0] OP_AND  = 5'd10;
  localparam logic [4:0] OP_OR   = 5'd11;
  localparam logic [4:0] OP_ADDI = 5'd12;
  localparam logic [4:0] OP_ANDI = 5'd13;
  localparam logic [4:0] OP_ORI  = 5'd14;
  localparam logic [4:0] OP_MUL  = 5'd15;
  localparam logic [4:0] OP_DIV  = 5'd16;
  localparam logic [4:0] OP_NEG  = 5'd17;
  localparam logic [4:0] OP_NOT  = 5'd18;
  localparam logic [4:0] OP_BR   = 5'd19;
  localparam logic [4:0] OP_JR   = 5'd20;
  localparam logic [4:0] OP_JAL  = 5'd21;
  localparam logic [4:0] OP_IN   = 5'd22;
  localparam logic [4:0] OP_OUT  = 5'd23;
  localparam logic [4:0] OP_MFHI = 5'd24;
  localparam logic [4:0] OP_MFLO = 5'd25;
  localparam logic [4:0] OP_NOP  = 5'd26;
  localparam logic [4:0] OP_HALT = 5'd27;

  typedef enum logic [3:0] {
    RESET = 4'd0, T0 = 4'd1, T1 = 4'd2, T2 = 4'd3, T3 = 4'd4,
    T4 = 4'd5, T5 = 4'd6, T6 = 4'd7, T7 = 4'd8, HALT = 4'd9
  } state_t;

  typedef struct packed {
    logic pc_out, zhigh_out, zlow_out, hi_out, lo_out, mdr_out, inport_out, c_out;
    logic mar_in, pc_in, mdr_in, ir_in, y_in, hi_in, lo_in, zhigh_in, zlow_in;
    logic outport_in, con_in;
    logic inc_pc, read, write, gra, grb, grc, r_in, r_out, ba_out;
  } strobes_t;

  // Number of execute steps (T3 onward) before returning to T0.
  function automatic logic [2:0] exec_len(logic [4:0] opc);
    case (opc)
      OP_LD, OP_ST:                                   exec_len = 3'd5;
      OP_MUL, OP_DIV, OP_BR:                          exec_len = 3'd4;
      OP_LDI, OP_ADD, OP_SUB, OP_SHR, OP_SHRA, OP_SHL,
      OP_ROR, OP_ROL, OP_AND, OP_OR, OP_ADDI, OP_ANDI,
      OP_ORI:                                         exec_len = 3'd3;
      OP_NEG, OP_NOT, OP_JAL:                         exec_len = 3'd2;
      OP_JR, OP_IN, OP_OUT, OP_MFHI, OP_MFLO:         exec_len = 3'd1;
      default:                                        exec_len = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/control_unit.sv
// Hardwired Moore control unit for the Mini-SRC single-bus datapath:
// state register plus combinational next-state and strobe decode.
//
// state | meaning
// RESET | held while clear=1; first edge after release goes to T0
// T0    | fetch: PC to MAR, increment PC (held here while stop=1)
// T1    | fetch: memory read into MDR, PC updated
// T2    | fetch: MDR to IR, branch on opcode
// T3-T7 | execute steps for the current opcode
// HALT  | absorbing until clear
module control_unit
  import src_pkg::*;
#(
  parameter int IR_W    = src_pkg::IR_W,
  parameter int OPC_MSB = src_pkg::OPC_MSB
) (
  input  logic            clock,
  input  logic            clear,
  input  logic [IR_W-1:0] ir,
  input  logic            con_ff,
  input  logic            stop,
  output logic            run,
  output logic PCout, Zhighout, Zlowout, HIout, LOout, MDRout, InPortout, Cout,
  output logic MARin, PCin, MDRin, IRin, Yin, HIin, LOin, Zhighin, Zlowin, OutPortin, CONin,
  output logic IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout
);

  state_t     state_q, state_d;
  strobes_t   s;
  logic [4:0] opc;
  logic [2:0] len;
  logic       unused_ir;

  assign opc       = ir[OPC_MSB -: 5];
  assign len       = exec_len(opc);
  assign unused_ir = ^ir;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) state_q <= RESET;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RESET: state_d = T0;
      T0:    state_d = stop ? T0 : T1;
      T1:    state_d = T2;
      T2: begin
        if (opc == OP_HALT)   state_d = HALT;
        else if (len == 3'd0) state_d = T0;
        else                  state_d = T3;
      end
      T3, T4, T5, T6, T7: begin
        // Step number of T3 is 1; leave when the opcode's last step is reached.
        if ({1'b0, len} == (4'(state_q) - 4'(T2))) state_d = T0;
        else                                       state_d = state_t'(4'(state_q) + 4'd1);
      end
      HALT:    state_d = HALT;
      default: state_d = RESET;
    endcase
  end

  always_comb begin
    s = '0;
    case (state_q)
      T0: if (!stop) begin s.pc_out = 1'b1; s.mar_in = 1'b1; s.inc_pc = 1'b1; s.zlow_in = 1'b1; end
      T1: begin s.zlow_out = 1'b1; s.pc_in = 1'b1; s.read = 1'b1; s.mdr_in = 1'b1; end
      T2: begin s.mdr_out = 1'b1; s.ir_in = 1'b1; end
      T3, T4, T5, T6, T7: begin
        case (opc)
          OP_ADD, OP_SUB, OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL, OP_AND, OP_OR,
          OP_ADDI, OP_ANDI, OP_ORI, OP_LDI, OP_LD, OP_ST: begin
            case (state_q)
              T3: begin
                s.grb = 1'b1; s.y_in = 1'b1;
                if (opc == OP_LDI || opc == OP_LD || opc == OP_ST) s.ba_out = 1'b1;
                else                                               s.r_out  = 1'b1;
              end
              T4: begin
                s.zlow_in = 1'b1;
                if (opc >= OP_ADD && opc <= OP_OR) begin s.grc = 1'b1; s.r_out = 1'b1; end
                else                                 s.c_out = 1'b1;
              end
              T5: begin
                s.zlow_out = 1'b1;
                if (opc == OP_LD || opc == OP_ST) s.mar_in = 1'b1;
                else begin s.gra = 1'b1; s.r_in = 1'b1; end
              end
              T6: begin
                s.mdr_in = 1'b1;
                if (opc == OP_LD) s.read = 1'b1;
                else begin s.gra = 1'b1; s.r_out = 1'b1; end
              end
              T7: begin
                if (opc == OP_LD) begin s.mdr_out = 1'b1; s.gra = 1'b1; s.r_in = 1'b1; end
                else                s.write = 1'b1;
              end
              default: ;
            endcase
          end
          OP_MUL, OP_DIV: begin
            case (state_q)
              T3: begin s.gra = 1'b1; s.r_out = 1'b1; s.y_in = 1'b1; end
              T4: begin s.grb = 1'b1; s.r_out = 1'b1; s.zhigh_in = 1'b1; s.zlow_in = 1'b1; end
              T5: begin s.zlow_out = 1'b1; s.lo_in = 1'b1; end
              T6: begin s.zhigh_out = 1'b1; s.hi_in = 1'b1; end
              default: ;
            endcase
          end
          OP_NEG, OP_NOT: begin
            if (state_q == T3) begin s.grb = 1'b1; s.r_out = 1'b1; s.zlow_in = 1'b1; end
            if (state_q == T4) begin s.zlow_out = 1'b1; s.gra = 1'b1; s.r_in = 1'b1; end
          end
          OP_BR: begin
            case (state_q)
              T3: begin s.gra = 1'b1; s.r_out = 1'b1; s.con_in = 1'b1; end
              T4: begin s.pc_out = 1'b1; s.y_in = 1'b1; end
              T5: begin s.c_out = 1'b1; s.zlow_in = 1'b1; end
              T6: if (con_ff) begin s.zlow_out = 1'b1; s.pc_in = 1'b1; end
              default: ;
            endcase
          end
          OP_JAL: begin
            if (state_q == T3) begin s.pc_out = 1'b1; s.grb = 1'b1; s.r_in = 1'b1; end
            if (state_q == T4) begin s.gra = 1'b1; s.r_out = 1'b1; s.pc_in = 1'b1; end
          end
          OP_JR:   if (state_q == T3) begin s.gra = 1'b1; s.r_out = 1'b1; s.pc_in = 1'b1; end
          OP_IN:   if (state_q == T3) begin s.inport_out = 1'b1; s.gra = 1'b1; s.r_in = 1'b1; end
          OP_OUT:  if (state_q == T3) begin s.gra = 1'b1; s.r_out = 1'b1; s.outport_in = 1'b1; end
          OP_MFHI: if (state_q == T3) begin s.hi_out = 1'b1; s.gra = 1'b1; s.r_in = 1'b1; end
          OP_MFLO: if (state_q == T3) begin s.lo_out = 1'b1; s.gra = 1'b1; s.r_in = 1'b1; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign run = (state_q != RESET) && (state_q != HALT) && !(state_q == T0 && stop);

  assign PCout     = s.pc_out;     assign Zhighout  = s.zhigh_out;
  assign Zlowout   = s.zlow_out;   assign HIout     = s.hi_out;
  assign LOout     = s.lo_out;     assign MDRout    = s.mdr_out;
  assign InPortout = s.inport_out; assign Cout      = s.c_out;
  assign MARin     = s.mar_in;     assign PCin      = s.pc_in;
  assign MDRin     = s.mdr_in;     assign IRin      = s.ir_in;
  assign Yin       = s.y_in;       assign HIin      = s.hi_in;
  assign LOin      = s.lo_in;      assign Zhighin   = s.zhigh_in;
  assign Zlowin    = s.zlow_in;    assign OutPortin = s.outport_in;
  assign CONin     = s.con_in;     assign IncPC     = s.inc_pc;
  assign Read      = s.read;       assign Write     = s.write;
  assign Gra       = s.gra;        assign Grb       = s.grb;
  assign Grc       = s.grc;        assign Rin       = s.r_in;
  assign Rout      = s.r_out;      assign BAout     = s.ba_out;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: stimulus pushes the expected per-cycle
// strobe word, a negedge monitor pops and compares against the DUT.
module tb_control_unit;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic [31:0] ir = '0;
  logic        con_ff = 1'b0;
  logic        stop = 1'b0;
  logic run;
  logic PCout, Zhighout, Zlowout, HIout, LOout, MDRout, InPortout, Cout;
  logic MARin, PCin, MDRin, IRin, Yin, HIin, LOin, Zhighin, Zlowin, OutPortin, CONin;
  logic IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout;

  always #5 clock = ~clock;

  control_unit dut (
    .clock(clock), .clear(clear), .ir(ir), .con_ff(con_ff), .stop(stop), .run(run),
    .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .HIout(HIout), .LOout(LOout),
    .MDRout(MDRout), .InPortout(InPortout), .Cout(Cout),
    .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .HIin(HIin),
    .LOin(LOin), .Zhighin(Zhighin), .Zlowin(Zlowin), .OutPortin(OutPortin), .CONin(CONin),
    .IncPC(IncPC), .Read(Read), .Write(Write), .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .Rin(Rin), .Rout(Rout), .BAout(BAout)
  );

  logic [28:0] act;
  assign act = {run, BAout, Rout, Rin, Grc, Grb, Gra, Write, Read, IncPC, CONin, OutPortin,
                Zlowin, Zhighin, LOin, HIin, Yin, IRin, MDRin, PCin, MARin, Cout, InPortout,
                MDRout, LOout, HIout, Zlowout, Zhighout, PCout};

  localparam logic [28:0] PCO  = 29'h1 << 0,  ZHO  = 29'h1 << 1,  ZLO  = 29'h1 << 2;
  localparam logic [28:0] HIO  = 29'h1 << 3,  LOO  = 29'h1 << 4,  MDRO = 29'h1 << 5;
  localparam logic [28:0] IPO  = 29'h1 << 6,  CO   = 29'h1 << 7,  MARI = 29'h1 << 8;
  localparam logic [28:0] PCI  = 29'h1 << 9,  MDRI = 29'h1 << 10, IRI  = 29'h1 << 11;
  localparam logic [28:0] YI   = 29'h1 << 12, HII  = 29'h1 << 13, LOI  = 29'h1 << 14;
  localparam logic [28:0] ZHI  = 29'h1 << 15, ZLI  = 29'h1 << 16, OPI  = 29'h1 << 17;
  localparam logic [28:0] CONI = 29'h1 << 18, INC  = 29'h1 << 19, RD   = 29'h1 << 20;
  localparam logic [28:0] WR   = 29'h1 << 21, GRA  = 29'h1 << 22, GRB  = 29'h1 << 23;
  localparam logic [28:0] GRC  = 29'h1 << 24, RI   = 29'h1 << 25, RO   = 29'h1 << 26;
  localparam logic [28:0] BA   = 29'h1 << 27, RUN  = 29'h1 << 28;

  localparam logic [4:0] O_LD = 5'd0, O_ST = 5'd2, O_ADD = 5'd3, O_MUL = 5'd15;
  localparam logic [4:0] O_BR = 5'd19, O_NOP = 5'd26, O_HALT = 5'd27;

  logic [28:0] exp_q[$];
  logic [28:0] seq[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(negedge clock) begin
    cyc++;
    if (exp_q.size() > 0) begin
      logic [28:0] e;
      e = exp_q.pop_front();
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL cycle_%0d strobes got=%h expected=%h", cyc, act, e);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [28:0] e);
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", nm, act, e);
    end
  endtask

  task automatic ex(input logic [28:0] v);
    seq.push_back(v | RUN);
  endtask

  // Reference: the strobe word for every cycle of one instruction, T0 first.
  task automatic build(input logic [4:0] opc, input logic c);
    seq.delete();
    ex(PCO | MARI | INC | ZLI);
    ex(ZLO | PCI | RD | MDRI);
    ex(MDRO | IRI);
    if (opc >= 5'd3 && opc <= 5'd11) begin
      ex(GRB | RO | YI); ex(GRC | RO | ZLI); ex(ZLO | GRA | RI);
    end else if (opc >= 5'd12 && opc <= 5'd14) begin
      ex(GRB | RO | YI); ex(CO | ZLI); ex(ZLO | GRA | RI);
    end else begin
      case (opc)
        5'd1: begin ex(GRB | BA | YI); ex(CO | ZLI); ex(ZLO | GRA | RI); end
        5'd0: begin
          ex(GRB | BA | YI); ex(CO | ZLI); ex(ZLO | MARI); ex(RD | MDRI); ex(MDRO | GRA | RI);
        end
        5'd2: begin
          ex(GRB | BA | YI); ex(CO | ZLI); ex(ZLO | MARI); ex(GRA | RO | MDRI); ex(WR);
        end
        5'd15, 5'd16: begin
          ex(GRA | RO | YI); ex(GRB | RO | ZHI | ZLI); ex(ZLO | LOI); ex(ZHO | HII);
        end
        5'd17, 5'd18: begin ex(GRB | RO | ZLI); ex(ZLO | GRA | RI); end
        5'd19: begin
          ex(GRA | RO | CONI); ex(PCO | YI); ex(CO | ZLI); ex(c ? (ZLO | PCI) : 29'h0);
        end
        5'd20: ex(GRA | RO | PCI);
        5'd21: begin ex(PCO | GRB | RI); ex(GRA | RO | PCI); end
        5'd22: ex(IPO | GRA | RI);
        5'd23: ex(GRA | RO | OPI);
        5'd24: ex(HIO | GRA | RI);
        5'd25: ex(LOO | GRA | RI);
        default: ;
      endcase
    end
  endtask

  task automatic run_instr(input logic [4:0] opc, input int pause, input int br_c);
    logic c;
    c = (br_c < 0) ? 1'($urandom_range(0, 1)) : br_c[0];
    build(opc, c);
    ir = {opc, 27'($urandom)};
    repeat (pause) begin
      stop = 1'b1;
      con_ff = 1'($urandom_range(0, 1));
      exp_q.push_back(29'h0);
      tick();
    end
    foreach (seq[i]) begin
      stop = (i == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      con_ff = (opc == O_BR && i == 6) ? c : 1'($urandom_range(0, 1));
      exp_q.push_back(seq[i]);
      tick();
    end
  endtask

  initial begin
    logic [4:0] opc;
    #3;
    chk("reset_state", 29'h0);
    @(posedge clock);
    #1;
    clear = 1'b0;
    exp_q.push_back(29'h0);
    tick();

    run_instr(O_ADD, 0, -1);
    run_instr(O_ST, 0, -1);
    run_instr(O_BR, 0, 1);
    run_instr(O_BR, 0, 0);
    run_instr(O_MUL, 2, -1);
    run_instr(O_NOP, 0, -1);
    run_instr(5'd31, 3, -1);
    for (int k = 0; k < 40; k++) begin
      opc = 5'($urandom_range(0, 31));
      if (opc == O_HALT) opc = O_NOP;
      run_instr(opc, int'($urandom_range(0, 2)), -1);
    end

    // clear in the middle of ld T6
    build(O_LD, 1'b0);
    ir = {O_LD, 27'($urandom)};
    for (int i = 0; i < 6; i++) begin
      stop = (i == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      exp_q.push_back(seq[i]);
      tick();
    end
    chk("ld_t6", seq[6]);
    #1 clear = 1'b1;
    #1 chk("clear_async", 29'h0);
    tick();
    chk("clear_held", 29'h0);
    clear = 1'b0;
    exp_q.push_back(29'h0);
    tick();
    run_instr(O_ADD, 0, -1);

    run_instr(O_HALT, 0, -1);
    repeat (22) begin
      stop = 1'($urandom_range(0, 1));
      exp_q.push_back(29'h0);
      tick();
    end
    #1 clear = 1'b1;
    #1 chk("clear_from_halt", 29'h0);
    tick();
    clear = 1'b0;
    exp_q.push_back(29'h0);
    tick();
    run_instr(O_NOP, 1, -1);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d expected=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
